mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
// Parametrised multicycle MIPS-subset core; successor to the single-state non-pipelined CPU.
// - Fetches over a valid/req handshake, so instruction memory may stall.
// - Sequences FETCH/DECODE/EXECUTE/WRITEBACK; retires one instruction per >=4 cycles.
// - Adds real BEQ/BNE redirection, OR, a writeback-correct register file, retire and illegal-op flags.
// PARAMETERS
// DATA_W    32           datapath/register/PC width; legal values 32 or 64 only
// NREGS     32           architectural registers, 8..32; fields >= NREGS read 0, writes dropped
// PC_RESET  0            PC value loaded on reset (word aligned)
// PORTS
// clk          in   1       rising-edge clock
// reset        in   1       synchronous, active-high reset
// imem_req     out  1       fetch request; high only in FETCH
// imem_addr    out  DATA_W  fetch address (= pc) while imem_req=1, else 0
// imem_valid   in   1       imem_rdata valid this cycle; sampled only while imem_req=1
// imem_rdata   in   32      instruction word
// pc           out  DATA_W  current program counter
// result       out  DATA_W  ALU result of last retired instruction
// retire       out  1       one-cycle pulse in WRITEBACK
// illegal      out  1       sticky flag: unsupported opcode/funct retired
// BEHAVIOUR
// Reset (synchronous, active-high; overrides everything, including a mid-fetch wait):
// - state=FETCH, pc=PC_RESET, all registers 0, IR/A/B/ALUOUT 0.
// - result=0, retire=0, illegal=0, imem_req=1 on the first cycle after reset.
// FSM:
// - FETCH: imem_req=1. Stay until imem_valid=1, then IR<=imem_rdata -> DECODE. No timeout.
// - DECODE: A<=R[rs], B<=R[rt], IMM<=sext(IR[15:0]) to DATA_W -> EXECUTE.
// - EXECUTE: ALUOUT computed; branch-taken flag and next-PC computed -> WRITEBACK.
// - WRITEBACK: register write (if any), pc<=next-PC, result<=ALUOUT, retire=1 -> FETCH.
// Latency: 4 cycles per instruction when imem_valid=1 in the first FETCH cycle; +1 per stall cycle.
// Decode, op=000000 (R-type), funct:
// - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed) -> write rd.
// - 001000 JR: next-PC=A, no register write.
// Decode, other opcodes:
// - 001000 ADDI: A+IMM -> write rt.
// - 000100 BEQ / 000101 BNE: ALUOUT=A-B; taken if zero / non-zero; no write.
// - 000010 J: next-PC={pc4[DATA_W-1:28], IR[25:0], 2'b00}.
// - Anything else: NOP (pc+4, no write), illegal<=1 sticky until reset.
// Arithmetic and PC rules:
// - All arithmetic modulo 2^DATA_W; overflow ignored, no trap. SLT result 1 or 0.
// - pc4=pc+4. Branch target=pc4+(IMM<<2). Not-taken and fall-through=pc4.
// - JR target used verbatim; low bits not forced to 0.
// - PC wraps modulo 2^DATA_W.
// Register file:
// - R0 always reads 0; writes to R0 and to index >= NREGS are discarded.
// - Write occurs in WRITEBACK; the next instruction's DECODE sees the new value (no hazard).
// Boundaries:
// - imem_valid while imem_req=0 is ignored.
// - imem_rdata only captured on the imem_valid=1 cycle.
// - result holds between retires; branches, J and JR also update result (ALUOUT).
// TESTING
// - Reset then imem_valid=1 always; ADDI r1,r0,5 ; ADDI r2,r0,-3 ; ADD r3,r1,r2 -> r3=2, retire every 4th cycle, pc=0xC.
// - SLT r4,r2,r1 with r2=-3,r1=5 -> r4=1. SUB r5,r2,r1 -> r5=0xFFFFFFF8.
// - BEQ r1,r1,+2 at pc=0x10 -> next pc=0x1C. BNE r1,r1,+2 -> pc=0x14. J 0x40 -> pc=0x100.
// - Hold imem_valid=0 for 3 cycles in FETCH -> imem_req stays 1, no retire; instruction retires 7 cycles after FETCH entry.
// - Write to r0 (ADDI r0,r0,7), then ADD r6,r0,r0 -> r6=0; with NREGS=8, ADDI r9,r0,1 -> dropped, r9 reads 0.
// - Opcode 111111 -> illegal=1 sticky, pc+=4. Assert reset in EXECUTE -> next cycle pc=PC_RESET, regs 0, illegal=0.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXECUTE/WRITEBACK over a stallable valid/req fetch port.
// ALUOUT for J is the jump target, for JR it is A, and for unsupported opcodes/functs it is 0.
module mips_multicycle_core #(
    parameter int                DATA_W   = 32,
    parameter int                NREGS    = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] result,
    output logic              retire,
    output logic              illegal,
    output logic [1:0]        dbg_state
);
    localparam int IDXW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t            state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_reg, b_reg, imm_reg, alu_out, next_pc;
    logic              wr_en, illegal_op;
    logic [4:0]        wr_idx;
    logic [DATA_W-1:0] regs [NREGS];

    logic [5:0]        op, fn;
    logic [4:0]        rs, rt;
    logic [DATA_W-1:0] rs_val, rt_val, pc4, diff;
    logic [DATA_W-1:0] ex_alu, ex_npc;
    logic              ex_wr, ex_ill;
    logic [4:0]        ex_idx;

    assign op        = ir[31:26];
    assign fn        = ir[5:0];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign pc4       = pc + DATA_W'(4);
    assign diff      = a_reg - b_reg;
    assign imem_addr = imem_req ? pc : '0;
    assign dbg_state = state;

    // R0 and indices beyond the implemented file read as zero.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && 32'(rs) < NREGS) rs_val = regs[rs[IDXW-1:0]];
        if (rt != 5'd0 && 32'(rt) < NREGS) rt_val = regs[rt[IDXW-1:0]];
    end

    always_comb begin
        ex_alu = '0;
        ex_npc = pc4;
        ex_wr  = 1'b0;
        ex_idx = ir[15:11];
        ex_ill = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD: begin ex_alu = a_reg + b_reg; ex_wr = 1'b1; end
                    FN_SUB: begin ex_alu = diff;          ex_wr = 1'b1; end
                    FN_AND: begin ex_alu = a_reg & b_reg; ex_wr = 1'b1; end
                    FN_OR:  begin ex_alu = a_reg | b_reg; ex_wr = 1'b1; end
                    FN_SLT: begin
                        ex_alu = DATA_W'($signed(a_reg) < $signed(b_reg));
                        ex_wr  = 1'b1;
                    end
                    FN_JR:  begin ex_alu = a_reg; ex_npc = a_reg; end
                    default: ex_ill = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ex_alu = a_reg + imm_reg;
                ex_wr  = 1'b1;
                ex_idx = ir[20:16];
            end
            OP_BEQ: begin
                ex_alu = diff;
                if (diff == '0) ex_npc = pc4 + (imm_reg << 2);
            end
            OP_BNE: begin
                ex_alu = diff;
                if (diff != '0) ex_npc = pc4 + (imm_reg << 2);
            end
            OP_J: begin
                ex_npc = {pc4[DATA_W-1:28], ir[25:0], 2'b00};
                ex_alu = {pc4[DATA_W-1:28], ir[25:0], 2'b00};
            end
            default: ex_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= PC_RESET;
            ir         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            imm_reg    <= '0;
            alu_out    <= '0;
            next_pc    <= '0;
            wr_en      <= 1'b0;
            wr_idx     <= '0;
            illegal_op <= 1'b0;
            result     <= '0;
            retire     <= 1'b0;
            illegal    <= 1'b0;
            imem_req   <= 1'b1;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg   <= rs_val;
                    b_reg   <= rt_val;
                    imm_reg <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
                    state   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_out    <= ex_alu;
                    next_pc    <= ex_npc;
                    wr_en      <= ex_wr;
                    wr_idx     <= ex_idx;
                    illegal_op <= ex_ill;
                    retire     <= 1'b1;
                    state      <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (wr_en && wr_idx != 5'd0 && 32'(wr_idx) < NREGS)
                        regs[wr_idx[IDXW-1:0]] <= alu_out;
                    pc       <= next_pc;
                    result   <= alu_out;
                    illegal  <= illegal | illegal_op;
                    retire   <= 1'b0;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed ISA cases plus randomized programs against an ISA-level model.
module tb_mips_multicycle_core;
    localparam int          DW  = 32;
    localparam int          NR  = 8;
    localparam logic [31:0] PCR = 32'h0;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_valid;
    logic [31:0]   imem_rdata;
    logic [DW-1:0] pc;
    logic [DW-1:0] result;
    logic          retire;
    logic          illegal;
    logic [1:0]    dbg_state;

    mips_multicycle_core #(.DATA_W(DW), .NREGS(NR), .PC_RESET(PCR)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc), .result(result),
        .retire(retire), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Architectural model state and expected-result scoreboard
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        m_illegal;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] r_type(input int s, input int t, input int d, input logic [5:0] f);
        r_type = {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] o, input int s, input int t, input logic [15:0] im);
        i_type = {o, 5'(s), 5'(t), im};
    endfunction

    function automatic logic [31:0] rd_reg(input int idx);
        rd_reg = (idx != 0 && idx < NR) ? m_regs[idx] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = PCR;
        m_illegal = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_exec(input logic [31:0] ins);
        logic [31:0] a, b, imm, pc4, npc, res;
        int wi;
        bit wr;
        a = rd_reg(int'(ins[25:21]));
        b = rd_reg(int'(ins[20:16]));
        imm = 32'($signed(ins[15:0]));
        pc4 = m_pc + 32'd4;
        npc = pc4;
        res = 32'h0;
        wr = 1'b0;
        wi = int'(ins[15:11]);
        case (ins[31:26])
            6'h00: begin
                wr = 1'b1;
                case (ins[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h08: begin res = a; npc = a; wr = 1'b0; end
                    default: begin m_illegal = 1'b1; wr = 1'b0; end
                endcase
            end
            6'h08: begin res = a + imm; wr = 1'b1; wi = int'(ins[20:16]); end
            6'h04: begin res = a - b; if (a == b) npc = pc4 + imm * 4; end
            6'h05: begin res = a - b; if (a != b) npc = pc4 + imm * 4; end
            6'h02: begin npc = {pc4[31:28], ins[25:0], 2'b00}; res = npc; end
            default: m_illegal = 1'b1;
        endcase
        if (wr && wi != 0 && wi < NR) m_regs[wi] = res;
        m_pc = npc;
        exp_q.push_back(res);
    endtask

    // Entered and left at a negedge inside a FETCH cycle.
    task automatic run_instr(input logic [31:0] ins, input int stall);
        int n;
        logic [31:0] exp;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_addr req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < stall; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || retire !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold req=%b retire=%b expected req=1 retire=0", imem_req, retire);
            end
        end
        imem_valid = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        model_exec(ins);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_drop req=%b expected 0", imem_req);
        end
        n = 1;
        while (retire !== 1'b1 && n < 12) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            n++;
        end
        checks++;
        if (retire !== 1'b1 || n != 3) begin
            errors++;
            $display("FAIL retire_latency retire=%b cycles_after_fetch=%0d expected 3", retire, n);
        end
        @(negedge clk);
        imem_valid = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (retire !== 1'b0 || imem_req !== 1'b1 || pc !== m_pc || result !== exp || illegal !== m_illegal) begin
            errors++;
            $display("FAIL retire_state ins=%h pc=%h result=%h illegal=%b retire=%b req=%b expected pc=%h result=%h illegal=%b retire=0 req=1",
                     ins, pc, result, illegal, retire, imem_req, m_pc, exp, m_illegal);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (pc !== PCR || result !== 32'h0 || retire !== 1'b0 || illegal !== 1'b0 ||
            imem_req !== 1'b1 || imem_addr !== PCR) begin
            errors++;
            $display("FAIL %s pc=%h result=%h retire=%b illegal=%b req=%b addr=%h expected pc=%h result=0 retire=0 illegal=0 req=1",
                     name, pc, result, retire, illegal, imem_req, imem_addr, PCR);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = $urandom;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        imem_valid = 1'b0;
        model_reset();
        check_reset_outputs("reset_state");
    endtask

    task automatic test_spec_sequence();
        run_instr(i_type(6'h08, 0, 1, 16'd5), 0);
        run_instr(i_type(6'h08, 0, 2, 16'hFFFD), 0);
        run_instr(r_type(1, 2, 3, 6'h20), 0);
        checks++;
        if (result !== 32'd2 || pc !== 32'hC) begin
            errors++;
            $display("FAIL add_literal result=%h pc=%h expected 2 and C", result, pc);
        end
        run_instr(r_type(2, 1, 4, 6'h2a), 0);
        checks++;
        if (result !== 32'd1) begin
            errors++;
            $display("FAIL slt_literal result=%h expected 1", result);
        end
        run_instr(i_type(6'h04, 1, 1, 16'd2), 0);
        checks++;
        if (pc !== 32'h1C) begin
            errors++;
            $display("FAIL beq_literal pc=%h expected 1C", pc);
        end
        run_instr(r_type(2, 1, 5, 6'h22), 0);
        checks++;
        if (result !== 32'hFFFFFFF8) begin
            errors++;
            $display("FAIL sub_literal result=%h expected FFFFFFF8", result);
        end
        run_instr(i_type(6'h05, 1, 1, 16'd2), 0);
        checks++;
        if (pc !== 32'h24) begin
            errors++;
            $display("FAIL bne_literal pc=%h expected 24", pc);
        end
        run_instr({6'h02, 26'h40}, 0);
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL j_literal pc=%h expected 100", pc);
        end
        run_instr(r_type(2, 0, 0, 6'h08), 0);
    endtask

    task automatic test_stall();
        run_instr(r_type(1, 2, 6, 6'h25), 3);
        run_instr(r_type(1, 2, 7, 6'h24), 1);
    endtask

    task automatic test_r0_and_nregs();
        run_instr(i_type(6'h08, 0, 0, 16'd7), 0);
        run_instr(r_type(0, 0, 6, 6'h20), 0);
        run_instr(i_type(6'h08, 0, 9, 16'd1), 0);
        run_instr(r_type(9, 0, 0, 6'h20), 0);
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL r9_dropped result=%h expected 0", result);
        end
        run_instr(i_type(6'h08, 0, 7, 16'h1234), 0);
        run_instr(r_type(7, 0, 0, 6'h20), 0);
    endtask

    task automatic test_illegal();
        run_instr({6'h3F, 26'h155_5555}, 0);
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_set illegal=%b expected 1", illegal);
        end
        run_instr(i_type(6'h08, 1, 3, 16'd9), 2);
        run_instr(r_type(1, 2, 3, 6'h3F), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        int s, t, d;
        logic [15:0] im;
        s = $urandom_range(0, 9);
        t = $urandom_range(0, 9);
        d = $urandom_range(0, 9);
        im = 16'($urandom);
        case ($urandom_range(0, 11))
            0:  rand_instr = r_type(s, t, d, 6'h20);
            1:  rand_instr = r_type(s, t, d, 6'h22);
            2:  rand_instr = r_type(s, t, d, 6'h24);
            3:  rand_instr = r_type(s, t, d, 6'h25);
            4:  rand_instr = r_type(s, t, d, 6'h2a);
            5, 6: rand_instr = i_type(6'h08, s, t, im);
            7:  rand_instr = i_type(6'h04, s, t, im);
            8:  rand_instr = i_type(6'h05, s, t, im);
            9:  rand_instr = {6'h02, 26'($urandom)};
            10: rand_instr = r_type(s, t, 0, 6'h08);
            default: rand_instr = i_type(6'h0D, s, t, im);
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 250; i++) run_instr(rand_instr(), $urandom_range(0, 2));
    endtask

    task automatic test_reset_mid();
        run_instr({6'h3F, 26'h0}, 0);
        run_instr(i_type(6'h08, 0, 4, 16'h00AA), 0);
        imem_valid = 1'b1;
        imem_rdata = i_type(6'h08, 0, 5, 16'h0055);
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL in_execute state=%0d expected 2", dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_outputs("reset_in_execute");
        for (int r = 1; r < NR; r++) run_instr(r_type(r, 0, 0, 6'h20), 0);
        run_instr(i_type(6'h08, 0, 3, 16'h0077), 0);
        imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_outputs("reset_in_fetch");
        run_instr(r_type(3, 0, 0, 6'h20), 1);
    endtask

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_spec_sequence();
        test_stall();
        test_r0_and_nregs();
        test_illegal();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
